// File: rtl/bv8_inv_pipe.sv
// Three-stage GF(2^8) inverter over the normal-basis tower GF(((2^2)^2)^2).
// Valid/ready handshake per stage with full back-pressure and bubble collapse.
module bv8_inv_pipe (
  input  logic       in_clock,
  input  logic       in_reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_a,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_c
);

  // Tower constants: N = W^2 in GF(2^2), nu = W*Z in GF(2^4); both have trace 1.
  localparam logic [3:0] NU = 4'b1000;

  function automatic logic [1:0] mul2(input logic [1:0] a, input logic [1:0] b);
    logic t;
    t = (a[1] ^ a[0]) & (b[1] ^ b[0]);
    return {(a[1] & b[1]) ^ t, (a[0] & b[0]) ^ t};
  endfunction

  function automatic logic [1:0] sq2(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  function automatic logic [1:0] scl_n2(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction

  function automatic logic [3:0] mul4(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] p;
    p = scl_n2(mul2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]));
    return {mul2(a[3:2], b[3:2]) ^ p, mul2(a[1:0], b[1:0]) ^ p};
  endfunction

  // Squaring over GF(2) is not the basis swap at this level because {Z, Z^4} are GF(4)-conjugates.
  function automatic logic [3:0] sq_scl4(input logic [3:0] a);
    logic [1:0] t;
    logic [3:0] sq;
    t  = scl_n2(sq2(a[3:2] ^ a[1:0]));
    sq = {sq2(a[3:2]) ^ t, sq2(a[1:0]) ^ t};
    return mul4(sq, NU);
  endfunction

  function automatic logic [3:0] inv4(input logic [3:0] a);
    logic [1:0] e;
    logic [1:0] ei;
    e  = mul2(a[3:2], a[1:0]) ^ scl_n2(sq2(a[3:2] ^ a[1:0]));
    ei = sq2(e);
    return {mul2(ei, a[1:0]), mul2(ei, a[3:2])};
  endfunction

  logic       v1_r, v2_r, v3_r;
  logic [3:0] ah1_r, al1_r, d1_r;
  logic [3:0] ah2_r, al2_r, dinv2_r;
  logic [7:0] c3_r;
  logic       r1_s, r2_s, r3_s;
  logic [3:0] d_s, dinv_s;
  logic [7:0] c_s;

  // Load enables ripple back from the output so empty slots absorb stalls.
  always_comb begin
    r3_s = !v3_r || out_ready;
    r2_s = !v2_r || r3_s;
    r1_s = !v1_r || r2_s;
  end

  // Per-stage field arithmetic.
  always_comb begin
    d_s    = mul4(in_a[7:4], in_a[3:0]) ^ sq_scl4(in_a[7:4] ^ in_a[3:0]);
    dinv_s = inv4(d1_r);
    c_s    = {mul4(dinv2_r, al2_r), mul4(dinv2_r, ah2_r)};
  end

  // Stage 1 register: operand halves and d.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      v1_r  <= 1'b0;
      ah1_r <= 4'h0;
      al1_r <= 4'h0;
      d1_r  <= 4'h0;
    end else if (r1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        ah1_r <= in_a[7:4];
        al1_r <= in_a[3:0];
        d1_r  <= d_s;
      end
    end
  end

  // Stage 2 register: inverse of d plus the forwarded halves.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      v2_r    <= 1'b0;
      ah2_r   <= 4'h0;
      al2_r   <= 4'h0;
      dinv2_r <= 4'h0;
    end else if (r2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        ah2_r   <= ah1_r;
        al2_r   <= al1_r;
        dinv2_r <= dinv_s;
      end
    end
  end

  // Stage 3 register: the result byte.
  always_ff @(posedge in_clock or posedge in_reset) begin
    if (in_reset) begin
      v3_r <= 1'b0;
      c3_r <= 8'h00;
    end else if (r3_s) begin
      v3_r <= v2_r;
      if (v2_r) begin
        c3_r <= c_s;
      end
    end
  end

  assign in_ready  = r1_s;
  assign out_valid = v3_r;
  assign out_c     = c3_r;

endmodule

// File: tb/tb_bv8_inv_pipe.sv
// Bench for bv8_inv_pipe: directed table of hand-computed inverses, then
// scoreboarded stream, back-pressure, bubble, reset and random-stall sequences.
module tb_bv8_inv_pipe;

  logic       in_clock = 1'b0;
  logic       in_reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c;

  bv8_inv_pipe dut (
    .in_clock (in_clock),
    .in_reset (in_reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_c    (out_c)
  );

  always #5 in_clock = ~in_clock;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] c;
  } vec_t;

  vec_t       vecs [8];
  int         n_vec = 0;
  int         n_bad = 0;
  int         n_acc = 0;
  int         n_emit = 0;
  logic [7:0] ref_inv [256];
  logic [7:0] exp_q [$];
  logic [7:0] src_q [$];
  logic       stalled = 1'b0;
  logic [7:0] held = 8'h00;

  // Reference multiplication written directly from the basis products.
  function automatic logic [1:0] r_mul2(input logic [1:0] a, input logic [1:0] b);
    logic x;
    x = (a[1] & b[0]) ^ (a[0] & b[1]);
    return {(a[0] & b[0]) ^ x, (a[1] & b[1]) ^ x};
  endfunction

  function automatic logic [3:0] r_mul4(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] p;
    p = r_mul2(r_mul2(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]), 2'b01);
    return {r_mul2(a[3:2], b[3:2]) ^ p, r_mul2(a[1:0], b[1:0]) ^ p};
  endfunction

  function automatic logic [7:0] r_mul8(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] p;
    p = r_mul4(r_mul4(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]), 4'b1000);
    return {r_mul4(a[7:4], b[7:4]) ^ p, r_mul4(a[3:0], b[3:0]) ^ p};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] a, input logic r);
    logic acc;
    logic emit;
    logic [7:0] e;
    logic [7:0] s;
    in_valid = v;
    in_a = a;
    out_ready = r;
    #1;
    if (stalled) begin
      chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_hold_data", {24'd0, out_c}, {24'd0, held});
    end
    acc  = in_valid & in_ready;
    emit = out_valid & out_ready;
    if (emit) begin
      n_emit++;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_output: got %0h, expected no output", out_c);
      end else begin
        e = exp_q.pop_front();
        s = src_q.pop_front();
        chk("stream_data", {24'd0, out_c}, {24'd0, e});
        if (s != 8'h00) chk("product_unity", {24'd0, r_mul8(out_c, s)}, 32'h0000_00ff);
      end
    end
    if (acc) begin
      n_acc++;
      exp_q.push_back(ref_inv[a]);
      src_q.push_back(a);
    end
    stalled = out_valid & !out_ready;
    held = out_c;
    @(negedge in_clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int got;
    int lat;
    int a0;
    int e0;

    vecs[0] = '{a: 8'h00, c: 8'h00};
    vecs[1] = '{a: 8'hff, c: 8'hff};
    vecs[2] = '{a: 8'haa, c: 8'h55};
    vecs[3] = '{a: 8'h55, c: 8'haa};
    vecs[4] = '{a: 8'h0f, c: 8'h30};
    vecs[5] = '{a: 8'hf0, c: 8'h03};
    vecs[6] = '{a: 8'h30, c: 8'h0f};
    vecs[7] = '{a: 8'h03, c: 8'hf0};

    ref_inv[0] = 8'h00;
    for (int a = 1; a < 256; a++) begin
      ref_inv[a] = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (r_mul8(8'(a), 8'(b)) == 8'hff) ref_inv[a] = 8'(b);
      end
    end

    in_reset = 1'b1;
    in_valid = 1'b0;
    in_a = 8'h00;
    out_ready = 1'b0;
    #2;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_c", {24'd0, out_c}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge in_clock);
    in_reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_a = vecs[i].a;
      out_ready = 1'b1;
      #1;
      chk("dir_in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge in_clock);
      in_valid = 1'b0;
      got = 0;
      lat = 0;
      for (int c = 1; c <= 8; c++) begin
        #1;
        if (got == 0 && out_valid) begin
          got = 1;
          lat = c;
          chk("dir_data", {24'd0, out_c}, {24'd0, vecs[i].c});
        end
        @(negedge in_clock);
        if (got != 0) break;
      end
      chk("dir_latency", lat, 32'd3);
    end

    // 00 then FF back-to-back: results in cycles 3 and 4 after the first acceptance.
    in_valid = 1'b1;
    in_a = 8'h00;
    out_ready = 1'b1;
    @(negedge in_clock);
    for (int c = 1; c <= 5; c++) begin
      in_valid = (c == 1);
      in_a = 8'hff;
      #1;
      chk("pair_valid", {31'd0, out_valid}, {31'd0, (c == 3 || c == 4)});
      if (c == 3) chk("pair_first", {24'd0, out_c}, 32'h00);
      if (c == 4) chk("pair_second", {24'd0, out_c}, 32'hff);
      @(negedge in_clock);
    end

    a0 = n_acc;
    e0 = n_emit;
    for (int i = 0; i < 256; i++) step(1'b1, 8'(i), 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("stream_accepted", n_acc - a0, 32'd256);
    chk("stream_emit_count", n_emit - e0, 32'd256);

    a0 = n_acc;
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h10 + i), 1'b0);
    chk("bp_accepted", n_acc - a0, 32'd3);
    in_valid = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    chk("bp_drained", exp_q.size(), 32'd0);

    a0 = n_acc;
    step(1'b1, 8'h21, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    in_valid = 1'b1;
    in_a = 8'h23;
    out_ready = 1'b0;
    #1;
    chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);
    step(1'b1, 8'h23, 1'b0);
    in_valid = 1'b1;
    in_a = 8'h24;
    #1;
    chk("bubble_full", {31'd0, in_ready}, 32'd0);
    chk("bubble_accepted", n_acc - a0, 32'd3);
    for (int i = 0; i < 6; i++) step(1'b0, 8'h00, 1'b1);
    chk("bubble_drained", exp_q.size(), 32'd0);

    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h31 + i), 1'b0);
    #2;
    in_reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_out_c", {24'd0, out_c}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    exp_q.delete();
    src_q.delete();
    stalled = 1'b0;
    @(negedge in_clock);
    in_reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("post_reset_idle", {31'd0, out_valid}, 32'd0);
      @(negedge in_clock);
    end

    a0 = n_acc;
    e0 = n_emit;
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("random_drained", exp_q.size(), 32'd0);
    chk("random_count", n_emit - e0, n_acc - a0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
